// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage.
// Optional halt detection is enabled with the FETCH_HALT_DETECT_EN macro.
package fetch_unit_pkg;

   localparam int B_DEF      = 32;
   localparam int ADDR_W_DEF = 7;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] PC_RESET   = 32'h0000_0000;

   // True when the word is the all-ones halt encoding.
   function automatic logic is_halt_instr(input logic [31:0] instr);
      return (instr == HALT_INSTR);
   endfunction

endpackage

// File: rtl/fetch_unit_hold_buffer.sv
// Hold buffer: keeps the instruction that was on the memory output when the
// pipeline stopped advancing, and selects what is presented to IF/ID.
module fetch_hold_buffer
   import fetch_unit_pkg::*;
#(
   parameter int B = B_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         capture,
   input  logic         clear,
   input  logic [B-1:0] rd_data,
   input  logic [B-1:0] rd_pc,
   input  logic         rd_valid,
   output logic [B-1:0] instr_sel,
   output logic [B-1:0] pc_plus1,
   output logic         hold_valid
);

   logic [B-1:0] hold_instr_r;
   logic [B-1:0] hold_pc_r;
   logic         hold_valid_r;

   // Capture the in-flight instruction once per stall; drop it when the stage moves on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_instr_r <= B'(NOP_INSTR);
         hold_pc_r    <= B'(PC_RESET);
         hold_valid_r <= 1'b0;
      end else if (clear) begin
         hold_valid_r <= 1'b0;
      end else if (capture && !hold_valid_r && rd_valid) begin
         hold_instr_r <= rd_data;
         hold_pc_r    <= rd_pc;
         hold_valid_r <= 1'b1;
      end
   end

   // Held instruction wins over the memory output; an empty slot presents a NOP.
   always_comb begin
      instr_sel = B'(NOP_INSTR);
      pc_plus1  = B'(PC_RESET);
      if (hold_valid_r) begin
         instr_sel = hold_instr_r;
         pc_plus1  = hold_pc_r + B'(1'b1);
      end else begin
         if (rd_valid) begin
            instr_sel = rd_data;
         end else begin
            instr_sel = B'(NOP_INSTR);
         end
         pc_plus1 = rd_pc + B'(1'b1);
      end
   end

   assign hold_valid = hold_valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, synchronous imem interface, stall
// handling through a hold buffer, branch redirects and IF/ID flush.
// Optional sticky halt on the all-ones instruction: FETCH_HALT_DETECT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int B      = B_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ena,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [B-1:0]      branch_target,
   input  logic [B-1:0]      imem_data,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_en,
   output logic [B-1:0]      instruction_out,
   output logic [B-1:0]      pc_incrementado_out,
   output logic              flush_out,
   output logic              halted
);

   logic [B-1:0] pc_r;
   logic [B-1:0] rd_pc_r;
   logic         rd_valid_r;
   logic         pend_valid_r;
   logic [B-1:0] pend_target_r;

   logic         halted_s;
   logic         adv_s;
   logic         redirect_s;
   logic         defer_s;
   logic [B-1:0] instr_s;
   logic [B-1:0] pc_plus1_s;
   logic         hold_valid_s;

`ifdef FETCH_HALT_DETECT_EN
   logic halted_r;
   logic go_s;
   logic halt_hit_s;

   // The halt word is caught before it advances, so the same cycle already
   // freezes the PC and parks the halt word in the hold buffer.
   assign go_s       = ena & ~stall & ~halted_r;
   assign redirect_s = ena & (branch_taken | pend_valid_r) & ~halted_r;
   assign halt_hit_s = go_s & ~redirect_s & is_halt_instr(32'(instr_s));
   assign adv_s      = go_s & ~halt_hit_s;
   assign halted_s   = halted_r;

   // Sticky halt flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted_r <= 1'b0;
      end else if (halt_hit_s) begin
         halted_r <= 1'b1;
      end
   end
`else
   assign halted_s   = 1'b0;
   assign redirect_s = ena & (branch_taken | pend_valid_r);
   assign adv_s      = ena & ~stall;
`endif

   // A branch arriving while frozen is remembered and applied once ena returns.
   assign defer_s = ~ena & branch_taken & ~halted_s;

   // PC, in-flight read tracking and deferred redirect; redirect overrides stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r          <= B'(PC_RESET);
         rd_pc_r       <= B'(PC_RESET);
         rd_valid_r    <= 1'b0;
         pend_valid_r  <= 1'b0;
         pend_target_r <= B'(PC_RESET);
      end else if (redirect_s) begin
         pc_r         <= branch_taken ? branch_target : pend_target_r;
         rd_valid_r   <= 1'b0;
         pend_valid_r <= 1'b0;
      end else if (defer_s) begin
         pend_valid_r  <= 1'b1;
         pend_target_r <= branch_target;
      end else if (adv_s) begin
         pc_r       <= pc_r + B'(1'b1);
         rd_pc_r    <= pc_r;
         rd_valid_r <= 1'b1;
      end
   end

   fetch_hold_buffer #(
      .B(B)
   ) u_hold (
      .clk        (clk),
      .reset      (reset),
      .capture    (~redirect_s & ~adv_s),
      .clear      (redirect_s | adv_s),
      .rd_data    (imem_data),
      .rd_pc      (rd_pc_r),
      .rd_valid   (rd_valid_r),
      .instr_sel  (instr_s),
      .pc_plus1   (pc_plus1_s),
      .hold_valid (hold_valid_s)
   );

   assign imem_addr           = pc_r[ADDR_W-1:0];
   assign imem_en             = adv_s & ~reset;
   assign flush_out           = redirect_s & ~reset;
   assign instruction_out     = instr_s;
   assign pc_incrementado_out = pc_plus1_s;
   assign halted              = halted_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous 128-word instruction memory.
// Halt checks follow FETCH_HALT_DETECT_EN when it is defined.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        ena;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_data;
   logic [6:0]  imem_addr;
   logic        imem_en;
   logic [31:0] instruction_out;
   logic [31:0] pc_incrementado_out;
   logic        flush_out;
   logic        halted;

   logic [31:0] mem [0:127];
   logic        scramble;
   int          n_assert;
   int          n_fail;

   fetch_unit #(.B(32), .ADDR_W(7)) dut (
      .clk                 (clk),
      .reset               (reset),
      .ena                 (ena),
      .stall               (stall),
      .branch_taken        (branch_taken),
      .branch_target       (branch_target),
      .imem_data           (imem_data),
      .imem_addr           (imem_addr),
      .imem_en             (imem_en),
      .instruction_out     (instruction_out),
      .pc_incrementado_out (pc_incrementado_out),
      .flush_out           (flush_out),
      .halted              (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory; output wanders randomly when not read and scramble is set.
   always @(posedge clk) begin
      if (imem_en) imem_data <= mem[imem_addr];
      else if (scramble) imem_data <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_pres(input string tag, input logic [31:0] ins, input logic [31:0] pc1);
      chk({tag, "_instr"}, instruction_out, ins);
      chk({tag, "_pc1"}, pc_incrementado_out, pc1);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0100 + 32'(i);
      mem[5] = 32'hFFFF_FFFF;
      imem_data = 32'h0; scramble = 1'b0;
      reset = 1'b0; ena = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      #2 reset = 1'b1;

      // reset state
      @(negedge clk); ena = 1'b1; #1;
      chk_pres("rst", 32'h0, 32'h1);
      chk("rst_addr", {25'b0, imem_addr}, 32'h0);
      chk("rst_en", {31'b0, imem_en}, 32'h0);
      chk("rst_flush", {31'b0, flush_out}, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'h0);

      // cycle 0: first fetch issued, NOP presented
      @(negedge clk); reset = 1'b0; #1;
      chk("c0_instr", instruction_out, 32'h0);
      chk("c0_en", {31'b0, imem_en}, 32'h1);
      chk("c0_addr", {25'b0, imem_addr}, 32'h0);
      @(negedge clk); #1; chk_pres("c1", 32'h100, 32'h1);
      @(negedge clk); #1; chk_pres("c2", 32'h101, 32'h2);

      // stall three cycles while 0x102 is presented, memory output randomised
      @(negedge clk); stall = 1'b1; scramble = 1'b1; #1;
      chk_pres("c3", 32'h102, 32'h3);
      chk("c3_en", {31'b0, imem_en}, 32'h0);
      @(negedge clk); #1; chk_pres("c4", 32'h102, 32'h3);
      @(negedge clk); #1; chk_pres("c5", 32'h102, 32'h3);
      @(negedge clk); stall = 1'b0; scramble = 1'b0; #1;
      chk_pres("c6_release", 32'h102, 32'h3);
      chk("c6_addr", {25'b0, imem_addr}, 32'h3);
      @(negedge clk); #1; chk_pres("c7", 32'h103, 32'h4);

      // branch during stall: redirect wins and flushes
      @(negedge clk); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; #1;
      chk("c8_flush", {31'b0, flush_out}, 32'h1);
      @(negedge clk); stall = 1'b0; branch_taken = 1'b0; #1;
      chk("c9_instr", instruction_out, 32'h0);
      chk("c9_flush", {31'b0, flush_out}, 32'h0);
      chk("c9_addr", {25'b0, imem_addr}, 32'h40);
      @(negedge clk); #1; chk_pres("c10", 32'h140, 32'h41);

      // branch while frozen is deferred until ena returns
      @(negedge clk); ena = 1'b0; branch_taken = 1'b1; branch_target = 32'h10; #1;
      chk("c11_flush", {31'b0, flush_out}, 32'h0);
      chk("c11_en", {31'b0, imem_en}, 32'h0);
      chk("c11_instr", instruction_out, 32'h141);
      @(negedge clk); branch_taken = 1'b0; #1;
      chk("c12_flush", {31'b0, flush_out}, 32'h0);
      chk("c12_instr", instruction_out, 32'h141);
      @(negedge clk); ena = 1'b1; #1;
      chk("c13_flush", {31'b0, flush_out}, 32'h1);
      @(negedge clk); #1;
      chk("c14_instr", instruction_out, 32'h0);
      chk("c14_addr", {25'b0, imem_addr}, 32'h10);
      @(negedge clk); #1; chk_pres("c15", 32'h110, 32'h11);

      // jump to 3 and run into the all-ones word at address 5
      @(negedge clk); branch_taken = 1'b1; branch_target = 32'h3; #1;
      chk("c16_flush", {31'b0, flush_out}, 32'h1);
      @(negedge clk); branch_taken = 1'b0; #1;
      chk("c17_addr", {25'b0, imem_addr}, 32'h3);
      @(negedge clk); #1; chk_pres("c18", 32'h103, 32'h4);
      @(negedge clk); #1; chk_pres("c19", 32'h104, 32'h5);
      @(negedge clk); #1; chk_pres("c20", 32'hFFFF_FFFF, 32'h6);
`ifdef FETCH_HALT_DETECT_EN
      chk("c20_en", {31'b0, imem_en}, 32'h0);
      @(negedge clk); #1;
      chk_pres("c21_halt", 32'hFFFF_FFFF, 32'h6);
      chk("c21_halted", {31'b0, halted}, 32'h1);
      chk("c21_en", {31'b0, imem_en}, 32'h0);
      @(negedge clk); branch_taken = 1'b1; branch_target = 32'h20; #1;
      chk("c22_flush", {31'b0, flush_out}, 32'h0);
      @(negedge clk); branch_taken = 1'b0; #1;
      chk_pres("c23_halt", 32'hFFFF_FFFF, 32'h6);
      chk("c23_addr", {25'b0, imem_addr}, 32'h6);
      chk("c23_halted", {31'b0, halted}, 32'h1);
      @(negedge clk); stall = 1'b1; #1;
      @(negedge clk); #1;
      chk_pres("hold_pre_rst", 32'hFFFF_FFFF, 32'h6);
`else
      chk("c20_en", {31'b0, imem_en}, 32'h1);
      @(negedge clk); #1;
      chk_pres("c21", 32'h106, 32'h7);
      chk("c21_halted", {31'b0, halted}, 32'h0);
      @(negedge clk); stall = 1'b1; #1;
      chk_pres("c22", 32'h107, 32'h8);
      @(negedge clk); #1;
      chk_pres("hold_pre_rst", 32'h107, 32'h8);
`endif

      // async reset mid-stall: outputs drop immediately, fetch restarts at 0
      #1 reset = 1'b1; #1;
      chk_pres("rst2", 32'h0, 32'h1);
      chk("rst2_en", {31'b0, imem_en}, 32'h0);
      chk("rst2_addr", {25'b0, imem_addr}, 32'h0);
      chk("rst2_halted", {31'b0, halted}, 32'h0);
      @(negedge clk); reset = 1'b0; stall = 1'b0; #1;
      chk("r0_instr", instruction_out, 32'h0);
      chk("r0_en", {31'b0, imem_en}, 32'h1);
      chk("r0_addr", {25'b0, imem_addr}, 32'h0);
      @(negedge clk); #1; chk_pres("r1", 32'h100, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
